// File: rtl/uart_msg_sequencer.sv
// uart_msg_sequencer: debounced push-button source that streams bytes from a
// small character ROM into a UART transmitter, one byte or one whole message
// per press. Optional receive echo is compiled in with UART_MSG_ECHO_EN.
module uart_msg_sequencer #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MSG_LEN    = 10,
    parameter int unsigned BASE_CHAR  = 48,
    parameter int unsigned SEND_MODE  = 0,
    parameter int unsigned DEBOUNCE_N = 5,
    parameter int unsigned SAMPLE_DIV = 1,
    parameter int unsigned ACK_TO     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_n,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_busy,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_rxne,
    output logic              rx_clear,
    output logic              active,
    output logic              err_timeout
);

    localparam int unsigned IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned TO_W  = (ACK_TO > 1) ? $clog2(ACK_TO + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        NEXT
    } state_t;

    // ROM contents are arithmetic, so no table is stored.
    function automatic logic [DATA_W-1:0] rom_byte(input logic [IDX_W-1:0] i);
        return DATA_W'(BASE_CHAR + 32'(i));
    endfunction

    // ---------------- button conditioning ----------------
    logic                  sync1;
    logic                  sync2;
    logic [DEBOUNCE_N-1:0] shreg;
    logic [DIV_W-1:0]      div_cnt;
    logic                  sample_tick;
    logic                  filt;
    logic                  filt_d;
    logic                  press;

    assign sample_tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign press       = filt & ~filt_d;

    // Two-flop synchroniser on the inverted (active-high) button.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= ~btn_n;
            sync2 <= sync1;
        end
    end

    // Sample divider, sample shift register and hysteresis filter.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            shreg   <= '0;
            filt    <= 1'b0;
            filt_d  <= 1'b0;
        end else begin
            div_cnt <= sample_tick ? '0 : div_cnt + DIV_W'(1);
            if (sample_tick) begin
                shreg <= (shreg << 1) | DEBOUNCE_N'(sync2);
            end
            if (&shreg) begin
                filt <= 1'b1;
            end else if (~|shreg) begin
                filt <= 1'b0;
            end
            filt_d <= filt;
        end
    end

    // ---------------- echo slot ----------------
    logic              echo_full;
    logic [DATA_W-1:0] echo_byte;
    logic              echo_clr_c;

`ifdef UART_MSG_ECHO_EN
    // Capture one received byte when the slot is free; clear it once sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            echo_full <= 1'b0;
            echo_byte <= '0;
            rx_clear  <= 1'b0;
        end else begin
            rx_clear <= 1'b0;
            if (echo_clr_c) begin
                echo_full <= 1'b0;
            end else if (rx_rxne && !echo_full) begin
                echo_full <= 1'b1;
                echo_byte <= rx_data;
                rx_clear  <= 1'b1;
            end
        end
    end
`else
    logic unused_rx;
    assign echo_full = 1'b0;
    assign echo_byte = '0;
    assign rx_clear  = 1'b0;
    assign unused_rx = ^{rx_data, rx_rxne, echo_clr_c};
`endif

    // ---------------- sequencer FSM ----------------
    state_t            state;
    state_t            state_n;
    logic              pend;
    logic              pend_n;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_n;
    logic              msg_run;
    logic              msg_run_n;
    logic              cur_echo;
    logic              cur_echo_n;
    logic [TO_W-1:0]   ack_cnt;
    logic [TO_W-1:0]   ack_cnt_n;
    logic              tx_valid_n;
    logic [DATA_W-1:0] tx_data_n;
    logic              err_n;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pend        <= 1'b0;
            idx         <= '0;
            msg_run     <= 1'b0;
            cur_echo    <= 1'b0;
            ack_cnt     <= '0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            err_timeout <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= state_n;
            pend        <= pend_n;
            idx         <= idx_n;
            msg_run     <= msg_run_n;
            cur_echo    <= cur_echo_n;
            ack_cnt     <= ack_cnt_n;
            tx_valid    <= tx_valid_n;
            tx_data     <= tx_data_n;
            err_timeout <= err_n;
            active      <= (state_n != IDLE);
        end
    end

    // Next-state logic; a byte is launched by loading tx_data/tx_valid on entry to SEND.
    always_comb begin
        state_n    = state;
        pend_n     = pend;
        idx_n      = idx;
        msg_run_n  = msg_run;
        cur_echo_n = cur_echo;
        ack_cnt_n  = ack_cnt;
        tx_valid_n = 1'b0;
        tx_data_n  = tx_data;
        err_n      = err_timeout;
        echo_clr_c = 1'b0;

        if (press && (state == IDLE)) begin
            pend_n = 1'b1;
        end

        case (state)
            IDLE: begin
                if (echo_full) begin
                    state_n    = SEND;
                    cur_echo_n = 1'b1;
                    tx_valid_n = 1'b1;
                    tx_data_n  = echo_byte;
                end else if (pend || press) begin
                    pend_n     = 1'b0;
                    state_n    = SEND;
                    cur_echo_n = 1'b0;
                    msg_run_n  = (SEND_MODE != 0);
                    tx_valid_n = 1'b1;
                    tx_data_n  = rom_byte(idx);
                end
            end
            SEND: begin
                state_n   = WAIT_ACK;
                ack_cnt_n = '0;
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_n = WAIT_DONE;
                end else if (ack_cnt == TO_W'(ACK_TO - 1)) begin
                    err_n   = 1'b1;
                    state_n = NEXT;
                end else begin
                    ack_cnt_n = ack_cnt + TO_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_n = NEXT;
                end
            end
            NEXT: begin
                if (cur_echo) begin
                    echo_clr_c = 1'b1;
                    if (msg_run) begin
                        state_n    = SEND;
                        cur_echo_n = 1'b0;
                        tx_valid_n = 1'b1;
                        tx_data_n  = rom_byte(idx);
                    end else begin
                        state_n = IDLE;
                    end
                end else if (idx == IDX_W'(MSG_LEN - 1)) begin
                    idx_n     = '0;
                    msg_run_n = 1'b0;
                    state_n   = IDLE;
                end else begin
                    idx_n = idx + IDX_W'(1);
                    if (!msg_run) begin
                        state_n = IDLE;
                    end else if (echo_full) begin
                        state_n    = SEND;
                        cur_echo_n = 1'b1;
                        tx_valid_n = 1'b1;
                        tx_data_n  = echo_byte;
                    end else begin
                        state_n    = SEND;
                        cur_echo_n = 1'b0;
                        tx_valid_n = 1'b1;
                        tx_data_n  = rom_byte(idx + IDX_W'(1));
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Bench for uart_msg_sequencer: one instance per send mode, each with a small
// UART busy model; transmitted bytes are logged and compared to hand values.
module tb_uart_msg_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn0 = 1'b1;
    logic       btn1 = 1'b1;
    logic       stuck0 = 1'b0;
    logic       busy0;
    logic       busy1;
    logic [7:0] tx_data0;
    logic [7:0] tx_data1;
    logic       tx_valid0;
    logic       tx_valid1;
    logic       rx_clear0;
    logic       rx_clear1;
    logic       active0;
    logic       active1;
    logic       err0;
    logic       err1;
    logic [7:0] rx_data1 = 8'h00;
    logic       rx_rxne1;
    int         rx_posts = 0;
    int         rx_acks = 0;
    int         busy_cnt0 = 0;
    int         busy_cnt1 = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         checks = 0;
    int         passes = 0;

    always #5 clk = ~clk;

    uart_msg_sequencer #(.SEND_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .btn_n(btn0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_busy(busy0),
        .rx_data(8'h00), .rx_rxne(1'b0), .rx_clear(rx_clear0),
        .active(active0), .err_timeout(err0)
    );

    uart_msg_sequencer #(.SEND_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .btn_n(btn1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_busy(busy1),
        .rx_data(rx_data1), .rx_rxne(rx_rxne1), .rx_clear(rx_clear1),
        .active(active1), .err_timeout(err1)
    );

    // UART models: busy for a fixed number of cycles after each send strobe.
    always @(posedge clk) begin
        if (rst) busy_cnt0 <= 0;
        else if (tx_valid0 && !stuck0) busy_cnt0 <= 3;
        else if (busy_cnt0 > 0) busy_cnt0 <= busy_cnt0 - 1;
        if (rst) busy_cnt1 <= 0;
        else if (tx_valid1) busy_cnt1 <= 20;
        else if (busy_cnt1 > 0) busy_cnt1 <= busy_cnt1 - 1;
        if (rx_clear1) rx_acks <= rx_acks + 1;
        if (tx_valid0) q0.push_back(tx_data0);
        if (tx_valid1) q1.push_back(tx_data1);
    end
    assign busy0    = (busy_cnt0 != 0);
    assign busy1    = (busy_cnt1 != 0);
    assign rx_rxne1 = (rx_posts != rx_acks);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_btn(input int which, input logic v);
        if (which == 0) btn0 = v;
        else btn1 = v;
    endtask

    task automatic pulse(input int which, input int low_cyc, input int high_cyc);
        @(posedge clk);
        #1 set_btn(which, 1'b0);
        repeat (low_cyc) @(posedge clk);
        #1 set_btn(which, 1'b1);
        repeat (high_cyc) @(posedge clk);
    endtask

    task automatic wait_q1(input int target, input int limit, output bit ok);
        int t = 0;
        while (q1.size() < target && t < limit) begin
            @(negedge clk);
            t++;
        end
        ok = (q1.size() >= target);
    endtask

    task automatic wait_idle1(input int limit, output bit ok);
        int t = 0;
        while (active1 && t < limit) begin
            @(negedge clk);
            t++;
        end
        ok = !active1;
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        int         low;
        int         exp_new;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int   n;
        int   t;
        bit   ok;
        logic [7:0] got;
        logic [7:0] exp_e[11];

        for (int i = 0; i < 10; i++) vecs[i] = '{12, 1, 8'(8'h30 + i)};
        vecs[10] = '{12, 1, 8'h30};
        for (int i = 0; i < 4; i++) vecs[11 + i] = '{i + 1, 0, 8'h00};

        // Reset state of both instances.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_data0", 32'(tx_data0), 0);
        check("rst_tx_valid0", 32'(tx_valid0), 0);
        check("rst_active0", 32'(active0), 0);
        check("rst_err0", 32'(err0), 0);
        check("rst_rx_clear0", 32'(rx_clear0), 0);
        check("rst_tx_valid1", 32'(tx_valid1), 0);
        check("rst_active1", 32'(active1), 0);
        check("rst_rx_clear1", 32'(rx_clear1), 0);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);

        // Mode 0: one byte per clean press with wrap; short glitches send nothing.
        for (int i = 0; i < 15; i++) begin
            n = q0.size();
            pulse(0, vecs[i].low, 30);
            check($sformatf("vec%0d_count", i), 32'(q0.size() - n), 32'(vecs[i].exp_new));
            if (vecs[i].exp_new == 1) begin
                got = (q0.size() > 0) ? q0[q0.size() - 1] : 8'h00;
                check($sformatf("vec%0d_byte", i), 32'(got), 32'(vecs[i].exp_byte));
            end
        end

        // Glitches of 1..4 samples then a 5-sample pulse: exact launch cycle.
        n = q0.size();
        for (int k = 1; k <= 4; k++) pulse(0, k, 20);
        @(posedge clk);
        #1 btn0 = 1'b0;
        repeat (5) @(posedge clk);
        #1 btn0 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("glitch_valid_edge8", 32'(tx_valid0), 0);
        @(posedge clk);
        @(negedge clk);
        check("glitch_valid_edge9", 32'(tx_valid0), 1);
        check("glitch_data_edge9", 32'(tx_data0), 32'h31);
        repeat (30) @(posedge clk);
        check("glitch_count", 32'(q0.size() - n), 1);

        // ACK timeout: no busy response; flag after the wait window, sticky until rst.
        stuck0 = 1'b1;
        @(posedge clk);
        #1 btn0 = 1'b0;
        t = 0;
        @(negedge clk);
        while (!tx_valid0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("to_valid_seen", 32'(tx_valid0), 1);
        check("to_byte", 32'(tx_data0), 32'h32);
        repeat (15) @(negedge clk);
        check("to_err_before", 32'(err0), 0);
        @(negedge clk);
        check("to_err_set", 32'(err0), 1);
        #1 btn0 = 1'b1;
        repeat (20) @(posedge clk);
        #1 stuck0 = 1'b0;
        n = q0.size();
        pulse(0, 12, 30);
        got = (q0.size() > n) ? q0[n] : 8'h00;
        check("to_advance_byte", 32'(got), 32'h33);
        check("to_err_sticky", 32'(err0), 1);
        do_reset();
        @(negedge clk);
        check("to_err_cleared", 32'(err0), 0);
        repeat (5) @(posedge clk);

        // Mode 1: whole message per press; a second press mid-message is dropped.
        n = q1.size();
        pulse(1, 12, 100);
        pulse(1, 12, 10);
        wait_idle1(600, ok);
        check("msg_idle", 32'(ok), 1);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("msg_count", 32'(q1.size() - n), 10);
        check("msg_active_low", 32'(active1), 0);
        for (int i = 0; i < 10; i++) begin
            got = (n + i < q1.size()) ? q1[n + i] : 8'h00;
            check($sformatf("msg_byte%0d", i), 32'(got), 32'(8'h30 + i));
        end

`ifdef UART_MSG_ECHO_EN
        // Echo byte inserted after 0x33, message resumes at 0x34.
        for (int i = 0; i < 4; i++) exp_e[i] = 8'(8'h30 + i);
        exp_e[4] = 8'h41;
        for (int i = 5; i < 11; i++) exp_e[i] = 8'(8'h2F + i);
        n = q1.size();
        t = rx_acks;
        pulse(1, 12, 0);
        wait_q1(n + 4, 200, ok);
        check("echo_reach_idx3", 32'(ok), 1);
        rx_data1 = 8'h41;
        rx_posts = rx_posts + 1;
        wait_idle1(600, ok);
        check("echo_idle", 32'(ok), 1);
        check("echo_rx_clear", 32'(rx_acks - t), 1);
        check("echo_count", 32'(q1.size() - n), 11);
        for (int i = 0; i < 11; i++) begin
            got = (n + i < q1.size()) ? q1[n + i] : 8'h00;
            check($sformatf("echo_byte%0d", i), 32'(got), 32'(exp_e[i]));
        end
`else
        exp_e[0] = 8'h00;
`endif

        // Reset during WAIT_DONE: outputs cleared next edge, message abandoned.
        n = q1.size();
        pulse(1, 12, 0);
        repeat (3) @(negedge clk);
        check("rmid_busy", 32'(active1), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rmid_tx_data", 32'(tx_data1), 0);
        check("rmid_tx_valid", 32'(tx_valid1), 0);
        check("rmid_active", 32'(active1), 0);
        check("rmid_err", 32'(err1), 0);
        check("rmid_rx_clear", 32'(rx_clear1), 0);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        check("rmid_abandoned", 32'(q1.size() - n), 1);
        n = q1.size();
        pulse(1, 12, 0);
        wait_q1(n + 1, 50, ok);
        check("rmid_restart_seen", 32'(ok), 1);
        got = (q1.size() > n) ? q1[n] : 8'h00;
        check("rmid_restart_byte", 32'(got), 32'h30);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/uart_msg_sequencer.md
# uart_msg_sequencer

Parametrised button-triggered UART message source for board bring-up: debounces an active-low user button and streams bytes from an internal character ROM into the UART transmitter. Each press sends either one byte or a whole message, per mode parameter. Optionally echoes received UART bytes. Sits between board I/O and the UART core on the PLL output clock domain.

## Interface
Parameters:
- DATA_W, 8, UART word width
- MSG_LEN, 10, ROM entries; ROM[i] = BASE_CHAR + i, truncated to DATA_W
- BASE_CHAR, 48, first character (ASCII '0')
- SEND_MODE, 0, 0 = one byte per press, 1 = whole message per press
- DEBOUNCE_N, 5, consecutive equal samples required to change filtered state
- SAMPLE_DIV, 1, clocks per debounce sample (≥1)
- ACK_TO, 15, max cycles to wait for tx_busy after tx_valid

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- btn_n  in  1  raw button, active low, asynchronous
- tx_data  out  DATA_W  byte to UART, valid with tx_valid
- tx_valid  out  1  one-cycle send strobe
- tx_busy  in  1  UART transmitter busy
- rx_data  in  DATA_W  received byte
- rx_rxne  in  1  receive buffer not empty
- rx_clear  out  1  one-cycle RXNE clear strobe
- active  out  1  high while FSM not in IDLE
- err_timeout  out  1  sticky; set on ACK timeout, cleared only by rst

## Operation
- Reset: all outputs 0, FSM IDLE, idx 0, filt 0, sync/shift registers 0 (button released), echo slot empty, pend 0.
- Debounce: btn_n inverted, then 2-flop synchroniser. Every SAMPLE_DIV cycles, sample shifts into DEBOUNCE_N-bit shift register. filt ← 1 when all ones, ← 0 when all zeros, else holds (hysteresis). press = filt & !filt_d, one cycle.
- press sets pend when FSM is IDLE; presses outside IDLE are discarded.
- FSM states: IDLE, SEND, WAIT_ACK, WAIT_DONE, NEXT.
- IDLE: if echo slot full → SEND with echo byte (echo has priority); else if pend → clear pend, SEND with ROM[idx].
- SEND: tx_valid=1, tx_data=selected byte for exactly one cycle; → WAIT_ACK, timeout counter 0.
- WAIT_ACK: tx_busy=1 → WAIT_DONE. Counter reaches ACK_TO → set err_timeout, → NEXT (byte treated as sent).
- WAIT_DONE: tx_busy=0 → NEXT.
- NEXT: if sent byte was echo → clear slot. If a ROM byte was sent: SEND_MODE 0 → idx ← (idx==MSG_LEN-1) ? 0 : idx+1, → IDLE. SEND_MODE 1 → if idx==MSG_LEN-1: idx ← 0, → IDLE; else idx+1; an echo byte pending here is sent first (→ SEND echo), then message resumes at idx.
- tx_data holds last sent value outside SEND.

## Timing
- SAMPLE_DIV=1, DEBOUNCE_N=5, btn_n held low from edge 0: synchroniser output edge 2, shift full edge 7, filt=1 edge 8, tx_valid high on cycle after edge 9.
- Release requires DEBOUNCE_N consecutive zero samples; single-sample glitches never change filt.
- Minimum byte cycle: SEND(1) + WAIT_ACK(≥1) + WAIT_DONE(≥1) + NEXT(1).
- Echo capture: rx_rxne=1 with slot empty → latch rx_data and pulse rx_clear the next cycle; with slot full, rx_rxne is left pending (no clear).
- Reset mid-message: everything returns to reset values next edge; partial message is abandoned.

## Configuration
- UART_MSG_ECHO_EN defined: echo slot, rx capture, rx_clear generation and echo priority compiled in.
- Not defined: rx_data/rx_rxne ignored, rx_clear tied 0, FSM never selects echo; ROM behaviour unchanged.

## Test plan
- SEND_MODE 0, 11 clean presses → tx_data sequence 0x30..0x39 then 0x30 (wrap), one tx_valid per press.
- SEND_MODE 1, one press, UART model busy 20 cycles per byte → exactly 10 tx_valid pulses 0x30..0x39, active low afterwards; second press mid-message ignored.
- btn_n low pulses of 1-4 samples, then 5 → single press only, tx_valid at cycle 9 of the final pulse.
- tx_busy stuck 0 → err_timeout set 15 cycles after tx_valid, sequencer advances to next byte, flag persists until rst.
- Echo enabled, rx_data=0x41 with rx_rxne during SEND_MODE 1 message at idx 3 → rx_clear pulse, 0x41 emitted after 0x33, then 0x34..0x39.
- rst asserted during WAIT_DONE → all outputs 0 next cycle; next press restarts at 0x30.
